// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit and the blocks
// that reuse its next-PC selector.
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;

    localparam logic [INSTR_W-1:0] HALT_CODE = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_ABS,
        PC_REL,
        PC_START
    } pc_sel_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: program handshake, InstROM address/data, decoder handoff
// and branch redirect. master = fetch unit, slave = its environment.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic [PC_W-1:0]    PC;
    logic [INSTR_W-1:0] mach_code;
    logic               stall;
    logic               branch_en;
    logic               branch_rel;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               done;

    modport master (
        input  start, start_addr, mach_code, stall,
        input  branch_en, branch_rel, branch_target,
        output PC, instr_out, instr_pc, instr_valid, done
    );

    modport slave (
        output start, start_addr, mach_code, stall,
        output branch_en, branch_rel, branch_target,
        input  PC, instr_out, instr_pc, instr_valid, done
    );

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection: hold, +1, absolute, relative and start address.
// All additions wrap modulo 2^PC_W; relative offsets are two's complement.
module pc_next
    import fetch_pkg::*;
(
    input  pc_sel_t         sel,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] instr_pc,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] start_addr,
    output logic [PC_W-1:0] pc_nxt
);

    always_comb begin
        pc_nxt = pc;
        case (sel)
            PC_HOLD:  pc_nxt = pc;
            PC_INC:   pc_nxt = pc + PC_W'(1);
            PC_ABS:   pc_nxt = branch_target;
            PC_REL:   pc_nxt = instr_pc + branch_target;
            PC_START: pc_nxt = start_addr;
            default:  pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, registers ROM data for the decoder,
// applies branch redirects and runs the start/done program handshake.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | fetching one word per cycle
//   HALT  | HALT_CODE issued, done=1, outputs frozen until start
module instr_fetch
    import fetch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    instr_fetch_if.master bus
);

    fetch_state_t       state;
    pc_sel_t            pc_sel;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_nxt;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    instr_pc_q;
    logic               valid_q;
    logic               done_q;
    logic               halt_hit;
    logic               branch_hit;

    assign halt_hit   = valid_q && (instr_q == HALT_CODE);
    assign branch_hit = valid_q && bus.branch_en;

    // Halt outranks branch; stall freezes everything including a pending branch.
    always_comb begin
        pc_sel = PC_HOLD;
        case (state)
            IDLE, HALT: if (bus.start) pc_sel = PC_START;
            RUN: begin
                if (!bus.stall && !halt_hit) begin
                    if (branch_hit) pc_sel = bus.branch_rel ? PC_REL : PC_ABS;
                    else            pc_sel = PC_INC;
                end
            end
            default: pc_sel = PC_HOLD;
        endcase
    end

    pc_next u_pc_next (
        .sel           (pc_sel),
        .pc            (pc_q),
        .instr_pc      (instr_pc_q),
        .branch_target (bus.branch_target),
        .start_addr    (bus.start_addr),
        .pc_nxt        (pc_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pc_q <= pc_nxt;
            case (state)
                IDLE, HALT: begin
                    if (bus.start) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        if (halt_hit) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= HALT;
                        end else if (branch_hit) begin
                            valid_q <= 1'b0;
                        end else begin
                            instr_q    <= bus.mach_code;
                            instr_pc_q <= pc_q;
                            valid_q    <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.PC          = pc_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a behavioural model of the fetch rules.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [INSTR_W-1:0] rom [256];
    assign bus.mach_code = rom[bus.PC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program is either running or not; when running, one word
    // issues per unstalled cycle unless the issued word halts or a branch redirects.
    bit                 m_live = 1'b0;
    bit                 m_run;
    logic [PC_W-1:0]    m_pc;
    logic [PC_W-1:0]    m_ipc;
    logic [INSTR_W-1:0] m_out;
    bit                 m_valid;
    bit                 m_done;

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1'b1; m_run = 1'b0;
            m_pc = 0; m_ipc = 0; m_out = 0; m_valid = 1'b0; m_done = 1'b0;
        end else if (m_live) begin
            if (!m_run) begin
                if (bus.start) begin
                    m_pc = bus.start_addr; m_valid = 1'b0; m_done = 1'b0; m_run = 1'b1;
                end
            end else if (!bus.stall) begin
                if (m_valid && m_out == HALT_CODE) begin
                    m_valid = 1'b0; m_done = 1'b1; m_run = 1'b0;
                end else if (m_valid && bus.branch_en) begin
                    m_pc    = bus.branch_rel ? PC_W'(int'(m_ipc) + int'(bus.branch_target))
                                             : bus.branch_target;
                    m_valid = 1'b0;
                end else begin
                    m_out = rom[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
                    m_pc  = PC_W'(int'(m_pc) + 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_pc", bus.PC, m_pc);
            chk("model_valid", bus.instr_valid, m_valid);
            chk("model_done", bus.done, m_done);
            if (m_valid || m_done) begin
                chk("model_instr_out", bus.instr_out, m_out);
                chk("model_instr_pc", bus.instr_pc, m_ipc);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.start = 0; bus.start_addr = 0; bus.stall = 0;
        bus.branch_en = 0; bus.branch_rel = 0; bus.branch_target = 0;
    endtask

    task automatic do_start(input logic [PC_W-1:0] addr);
        bus.start = 1; bus.start_addr = addr;
        cyc();
        bus.start = 0;
    endtask

    task automatic do_reset();
        reset = 1; cyc(); reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = INSTR_W'($urandom_range(0, 510));
        rom[8'h10] = 9'h001; rom[8'h11] = 9'h002; rom[8'h12] = 9'h003;
        rom[8'h13] = HALT_CODE;
        rom[8'h3F] = 9'h03F; rom[8'h40] = 9'h040; rom[8'h41] = 9'h041;
        rom[8'hFF] = 9'h0FF; rom[8'h00] = 9'h100; rom[8'h01] = 9'h101;
        quiet();
        reset = 1;

        // reset then idle
        cyc(); cyc();
        chk("rst_pc", bus.PC, 8'h00);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        reset = 0;
        repeat (3) cyc();
        chk("idle_pc", bus.PC, 8'h00);

        // straight-line fetch with stall
        do_start(8'h10);
        chk("start_pc", bus.PC, 8'h10);
        chk("start_valid", bus.instr_valid, 1'b0);
        cyc();
        chk("f0_out", bus.instr_out, 9'h001);
        chk("f0_ipc", bus.instr_pc, 8'h10);
        chk("f0_pc", bus.PC, 8'h11);
        cyc();
        chk("f1_out", bus.instr_out, 9'h002);
        chk("f1_ipc", bus.instr_pc, 8'h11);
        bus.stall = 1;
        bus.branch_en = 1; bus.branch_target = 8'h77;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_out", bus.instr_out, 9'h002);
            chk("stall_pc", bus.PC, 8'h12);
            chk("stall_valid", bus.instr_valid, 1'b1);
        end
        bus.stall = 0; bus.branch_en = 0;
        cyc();
        chk("f2_out", bus.instr_out, 9'h003);
        chk("f2_ipc", bus.instr_pc, 8'h12);

        // absolute branch at 12 -> 40
        bus.branch_en = 1; bus.branch_rel = 0; bus.branch_target = 8'h40;
        cyc();
        bus.branch_en = 0;
        chk("babs_bubble", bus.instr_valid, 1'b0);
        chk("babs_pc", bus.PC, 8'h40);
        cyc();
        chk("babs_ipc", bus.instr_pc, 8'h40);
        chk("babs_out", bus.instr_out, 9'h040);
        cyc();
        chk("seq_ipc", bus.instr_pc, 8'h41);

        // relative branch -2 at 41 -> 3F
        bus.branch_en = 1; bus.branch_rel = 1; bus.branch_target = 8'hFE;
        cyc();
        bus.branch_en = 0;
        chk("brel_bubble", bus.instr_valid, 1'b0);
        chk("brel_pc", bus.PC, 8'h3F);
        cyc();
        chk("brel_ipc", bus.instr_pc, 8'h3F);
        chk("brel_valid", bus.instr_valid, 1'b1);

        // wrap on increment
        do_reset();
        do_start(8'hFF);
        cyc();
        chk("wrap_ipc0", bus.instr_pc, 8'hFF);
        chk("wrap_pc0", bus.PC, 8'h00);
        cyc();
        chk("wrap_ipc1", bus.instr_pc, 8'h00);
        chk("wrap_out1", bus.instr_out, 9'h100);

        // wrap on relative add
        do_reset();
        do_start(8'hFF);
        cyc();
        bus.branch_en = 1; bus.branch_rel = 1; bus.branch_target = 8'h02;
        cyc();
        bus.branch_en = 0;
        chk("wrel_pc", bus.PC, 8'h01);
        cyc();
        chk("wrel_ipc", bus.instr_pc, 8'h01);
        chk("wrel_out", bus.instr_out, 9'h101);

        // halt with concurrent branch, then restart
        do_reset();
        do_start(8'h12);
        cyc();
        cyc();
        chk("halt_issue", bus.instr_out, HALT_CODE);
        bus.branch_en = 1; bus.branch_rel = 0; bus.branch_target = 8'h40;
        cyc();
        chk("halt_done", bus.done, 1'b1);
        chk("halt_valid", bus.instr_valid, 1'b0);
        chk("halt_pc", bus.PC, 8'h14);
        cyc();
        bus.branch_en = 0;
        chk("halt_hold_pc", bus.PC, 8'h14);
        chk("halt_hold_done", bus.done, 1'b1);
        do_start(8'h10);
        chk("restart_done", bus.done, 1'b0);
        chk("restart_pc", bus.PC, 8'h10);
        cyc();
        chk("restart_out", bus.instr_out, 9'h001);

        // reset mid-run with a simultaneous start
        reset = 1; bus.start = 1; bus.start_addr = 8'h55;
        cyc();
        reset = 0; bus.start = 0;
        chk("mrst_pc", bus.PC, 8'h00);
        chk("mrst_out", bus.instr_out, 9'h000);
        chk("mrst_ipc", bus.instr_pc, 8'h00);
        chk("mrst_valid", bus.instr_valid, 1'b0);
        chk("mrst_done", bus.done, 1'b0);
        cyc();
        chk("mrst_idle_pc", bus.PC, 8'h00);

        // random phase
        for (int i = 0; i < 256; i++)
            if ($urandom_range(0, 23) == 0) rom[i] = HALT_CODE;
        for (int n = 0; n < 4000; n++) begin
            reset             = ($urandom_range(0, 299) == 0);
            bus.start         = ($urandom_range(0, 14) == 0);
            bus.start_addr    = PC_W'($urandom);
            bus.stall         = ($urandom_range(0, 3) == 0);
            bus.branch_en     = ($urandom_range(0, 5) == 0);
            bus.branch_rel    = 1'($urandom);
            bus.branch_target = PC_W'($urandom);
            cyc();
        end
        reset = 0;
        quiet();
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator side of the instruction ROM interface. It owns the program counter and drives `PC` into `InstROM`. It captures the returned `mach_code` into an instruction register for the decoder and applies branch redirects. It runs the start/done program handshake with the top-level testbench. It sits between the top-level controller and the decode stage, one fetch per cycle, and supports stall, squash and halt.

## Interface
- `PC_W`, 8, program counter / ROM address width
- `INSTR_W`, 9, machine-code width
- `HALT_CODE`, 9'h1FF, encoding that ends the program
- `clk`  input  1  clock; everything is updated on the rising edge
- `reset`  input  1  synchronous, active-high; wins over all other inputs
- `start`  input  1  single-cycle pulse; begins execution at `start_addr`
- `start_addr`  input  PC_W  first instruction address
- `PC`  output  PC_W  address to `InstROM` (combinational ROM, data valid the same cycle)
- `mach_code`  input  INSTR_W  ROM data for `PC`
- `stall`  input  1  decoder back-pressure; freezes the unit
- `branch_en`  input  1  redirect request for the instruction currently on `instr_out`
- `branch_rel`  input  1  1 = `instr_pc` + signed `branch_target`, 0 = absolute `branch_target`
- `branch_target`  input  PC_W  target or signed offset (from the branch LUT)
- `instr_out`  output  INSTR_W  registered instruction to the decoder
- `instr_pc`  output  PC_W  address of `instr_out`
- `instr_valid`  output  1  `instr_out` is a live instruction
- `done`  output  1  program halted

## Operation
- States: IDLE, RUN, HALT.
- Reset:
  - State goes to IDLE.
  - `PC` = 0, `instr_out` = 0, `instr_pc` = 0, `instr_valid` = 0, `done` = 0.
- IDLE or HALT with `start`=1:
  - `PC` <= `start_addr`.
  - `instr_valid` <= 0 and `done` <= 0.
  - State goes to RUN.
- `start` during RUN is ignored.
- RUN with `stall`=0, no branch and no halt:
  - `instr_out` <= `mach_code`.
  - `instr_pc` <= `PC`.
  - `instr_valid` <= 1.
  - `PC` <= `PC`+1.
- RUN with `stall`=1:
  - `PC`, `instr_out`, `instr_pc` and `instr_valid` all hold.
  - `branch_en` is ignored; the decoder keeps it asserted until the stall drops.
- Branch: `branch_en`=1 with `instr_valid`=1 and `stall`=0:
  - `PC` <= target, where target = `branch_rel` ? `instr_pc`+`branch_target` (signed, mod 2^PC_W) : `branch_target`.
  - The word fetched this cycle is squashed: `instr_valid` <= 0 for one cycle (one bubble).
  - `branch_en` with `instr_valid`=0 is ignored.
- Halt: `instr_valid`=1, `instr_out`==HALT_CODE and `stall`=0:
  - `instr_valid` <= 0 and `PC` holds.
  - State goes to HALT and `done` <= 1.
  - Halt has priority over `branch_en`.
- In HALT, all outputs hold and `done` stays 1 until `start` or `reset`.
- Arithmetic: `PC` wraps from 8'hFF to 8'h00, both on increment and on relative add; there is no overflow flag.

## Timing
- `start` at cycle N:
  - `PC`=`start_addr` at N+1.
  - `instr_out`=ROM[`start_addr`], `instr_valid`=1, `PC`=`start_addr`+1 at N+2.
- Fetch-to-issue latency is 1 cycle; throughput is 1 instruction/cycle without stalls.
- Taken branch observed at cycle M gives `PC`=target at M+1, `instr_valid`=0 at M+1, and the target instruction valid at M+2.
- HALT_CODE on `instr_out` at cycle M gives `done`=1 at M+1.
- `reset` mid-RUN returns all outputs to their reset values at the next edge; a `start` in the same cycle is ignored.

## Structure
- Package `fetch_pkg` holds:
  - the state enum `fetch_state_t` (IDLE, RUN, HALT);
  - `HALT_CODE`;
  - the default widths `PC_W` and `INSTR_W`.
- Sub-module `pc_next`: combinational next-PC selection covering hold, +1, absolute, relative and `start_addr`. It is shared later with the branch LUT unit.
- `instr_fetch` instantiates `pc_next`, the state register and the instruction/PC/valid registers. `InstROM` stays outside the unit.

## Test plan
- Reset then idle: hold `reset`=1 two cycles -> `PC`=0, `instr_valid`=0, `done`=0; `PC` does not move while `start`=0.
- Straight-line fetch: `start` with `start_addr`=8'h10, ROM[10..12]=9'h001,9'h002,9'h003 -> `instr_out` issues 001,002,003 on consecutive cycles with `instr_pc`=10,11,12.
- Stall: `stall`=1 for 3 cycles while `instr_out`=9'h002 -> `PC`, `instr_out` and `instr_valid` are unchanged; issue resumes with 9'h003 the cycle after `stall` drops.
- Branches, each one bubble then target valid:
  - absolute `branch_target`=8'h40 at `instr_pc`=8'h12 -> next valid `instr_pc`=8'h40;
  - relative offset 8'hFE at `instr_pc`=8'h41 -> `instr_pc`=8'h3F.
- Wrap: `start_addr`=8'hFF -> `instr_pc` sequence FF, 00; relative offset 8'h02 at `instr_pc`=8'hFF -> target 8'h01.
- Halt/restart: HALT_CODE at ROM[8'h13], with `branch_en`=1 asserted in the same cycle -> `done`=1 one cycle after it issues, `PC` frozen, branch ignored; a new `start` -> `done`=0 and fetch resumes; `reset` asserted mid-RUN -> all outputs return to their reset values at the next edge.
